debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 53 +++++
 tb/tb_debounce_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel input synchronizer and asymmetric debouncer
// with registered rise/fall pulses, sticky change flags and an irq summary.
module debounce_bank #(
    parameter int                  CHANNELS    = 8,
    parameter int                  CYCLES_RISE = 160_000,
    parameter int                  CYCLES_FALL = 160_000,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] RESET_VAL   = '0
) (
    input  logic                aclk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] clear,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] changed,
    output logic                irq
);
    localparam int CW = $clog2((CYCLES_RISE > CYCLES_FALL ? CYCLES_RISE : CYCLES_FALL) + 1);
    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]       r_cnt  [CHANNELS];
    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_commit;
    // The target depends on the committed level, so rise and fall can use different hold times.
    always_comb begin
        w_s = r_sync[SYNC_STAGES-1];
        w_commit = '0;
        for (int c = 0; c < CHANNELS; c++)
            w_commit[c] = (w_s[c] != out[c]) &&
                          (r_cnt[c] == (out[c] ? CW'(CYCLES_FALL - 1) : CW'(CYCLES_RISE - 1)));
    end
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= RESET_VAL;
            for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
            out     <= RESET_VAL;
            rise    <= '0;
            fall    <= '0;
            changed <= '0;
        end else begin
            r_sync[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            for (int c = 0; c < CHANNELS; c++)
                r_cnt[c] <= (w_s[c] == out[c] || w_commit[c]) ? '0 : r_cnt[c] + 1'b1;
            out     <= out ^ w_commit;
            rise    <= w_commit & w_s;
            fall    <= w_commit & ~w_s;
            changed <= w_commit | (changed & ~clear);
        end
    end
    assign irq = |changed;
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed scenarios plus random stimulus against a
// history-window reference model of the debouncer.
module tb_debounce_bank;
    localparam int N = 4;
    localparam int R = 4;
    localparam int F = 6;
    localparam int S = 2;
    localparam logic [N-1:0] RV = '0;

    logic aclk = 0;
    logic reset = 0;
    logic [N-1:0] din = '0;
    logic [N-1:0] clr = '0;
    logic [N-1:0] out, rise, fall, changed;
    logic irq;
    int n_chk = 0;
    int n_err = 0;

    debounce_bank #(
        .CHANNELS(N), .CYCLES_RISE(R), .CYCLES_FALL(F), .SYNC_STAGES(S), .RESET_VAL(RV)
    ) dut (
        .aclk(aclk), .reset(reset), .in(din), .clear(clr), .out(out),
        .rise(rise), .fall(fall), .changed(changed), .irq(irq)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a channel commits once its last T synchronized samples all disagree with out.
    logic [N-1:0] pipe [$];
    logic [N-1:0] hist [$];
    logic [N-1:0] m_out, m_rise, m_fall, m_chg;
    always @(posedge aclk or posedge reset) begin
        logic [N-1:0] s, v;
        int t;
        bit ok;
        if (reset) begin
            pipe = {};
            for (int k = 0; k < S; k++) pipe.push_back(RV);
            hist = {};
            m_out = RV;
            m_rise = '0;
            m_fall = '0;
            m_chg = '0;
        end else begin
            s = pipe.pop_front();
            pipe.push_back(din);
            hist.push_back(s);
            if (hist.size() > 8) void'(hist.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N; c++) begin
                t = m_out[c] ? F : R;
                ok = hist.size() >= t;
                for (int k = 0; k < t && ok; k++) begin
                    v = hist[hist.size() - 1 - k];
                    if (v[c] == m_out[c]) ok = 0;
                end
                m_chg[c] = m_chg[c] & ~clr[c];
                if (ok) begin
                    m_rise[c] = s[c];
                    m_fall[c] = ~s[c];
                    m_out[c] = s[c];
                    m_chg[c] = 1'b1;
                end
            end
        end
    end

    always @(negedge aclk) begin
        chk("out", 32'(out), 32'(m_out));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("changed", 32'(changed), 32'(m_chg));
        chk("irq", 32'(irq), 32'(|m_chg));
        chk("rise_fall_excl", 32'(rise & fall), 32'(0));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    // Counts rising edges until out masked by m equals v; returns 99 on timeout.
    task automatic edges_until(input logic [N-1:0] m, input logic [N-1:0] v, output int n);
        n = 0;
        do begin
            @(posedge aclk);
            #1;
            n++;
        end while ((out & m) !== v && n < 40);
        if ((out & m) !== v) n = 99;
        #1;
    endtask

    initial begin
        int n;
        #1 reset = 1;
        step(3);
        chk("reset_out", 32'(out), 32'(RV));
        chk("reset_irq", 32'(irq), 32'(0));
        reset = 0;
        step(3);
        // Clean rise on channel 0.
        din = 4'b0001;
        edges_until(4'b0001, 4'b0001, n);
        chk("rise_latency", n, 6);
        chk("rise_pulse", 32'(rise), 32'(4'b0001));
        chk("irq_after_rise", 32'(irq), 32'(1));
        // Short pulse on channel 1 must be swallowed.
        step(1);
        din[1] = 1;
        step(3);
        din[1] = 0;
        step(10);
        chk("short_out1", 32'(out[1]), 32'(0));
        chk("short_chg1", 32'(changed[1]), 32'(0));
        // Falling edge with a one-cycle glitch restarting the count.
        din[0] = 0;
        step(4);
        din[0] = 1;
        step(1);
        din[0] = 0;
        edges_until(4'b0001, 4'b0000, n);
        chk("glitch_fall_latency", n, 8);
        chk("fall_pulse", 32'(fall), 32'(4'b0001));
        // Clear coinciding with a commit loses to the set.
        clr = 4'hF;
        step(1);
        clr = '0;
        step(2);
        din[0] = 1;
        step(5);
        clr = 4'b0001;
        step(1);
        chk("set_wins", 32'(changed[0]), 32'(1));
        step(1);
        clr = '0;
        chk("clear_alone", 32'(changed[0]), 32'(0));
        chk("irq_cleared", 32'(irq), 32'(0));
        // Reset in the middle of a channel-2 count.
        din[2] = 1;
        step(4);
        reset = 1;
        step(2);
        chk("mid_reset_out2", 32'(out[2]), 32'(0));
        chk("mid_reset_rise", 32'(rise), 32'(0));
        reset = 0;
        edges_until(4'b0100, 4'b0100, n);
        chk("post_reset_latency", n, 6);
        chk("post_reset_chg2", 32'(changed[2]), 32'(1));
        // All channels rising together.
        din = '0;
        step(12);
        din = 4'hF;
        edges_until(4'hF, 4'hF, n);
        chk("all_rise_latency", n, 6);
        chk("all_rise_pulse", 32'(rise), 32'(4'hF));
        // Random stimulus with sparse toggles so commits actually happen.
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(7) == 0) din[c] = ~din[c];
            clr = ($urandom_range(3) == 0) ? 4'($urandom) : '0;
            reset = ($urandom_range(499) == 0);
            step(1);
        end
        reset = 0;
        step(3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
